// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - in-flight register write tracker with decode-stage interlock
module register_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        issue_valid,
    input  logic        issue_regwrite,
    input  logic [4:0]  issue_rd,
    input  logic        wb_valid,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] pending,
    output logic [15:0] stall_cycles,
    output logic        sb_error
);

    // Per-register count of writes between issue and write-back; entry 0 stays zero.
    logic [1:0] cnt      [32];
    logic [1:0] cnt_next [32];

    logic       iss;
    logic       ret;
    logic       rs1_ret;
    logic       rs2_ret;
    logic       hazard_rs1;
    logic       hazard_rs2;
    logic       err_event;

    // Hazard detection: a producer retiring this cycle is forwarded, so it cancels one count.
    always_comb begin
        ret        = wb_valid & wb_regwrite & (wb_rd != 5'd0);
        rs1_ret    = ret & (wb_rd == id_rs1);
        rs2_ret    = ret & (wb_rd == id_rs2);
        hazard_rs1 = id_use_rs1 & (id_rs1 != 5'd0) & (cnt[id_rs1] != {1'b0, rs1_ret});
        hazard_rs2 = id_use_rs2 & (id_rs2 != 5'd0) & (cnt[id_rs2] != {1'b0, rs2_ret});
        stall      = ~flush & (hazard_rs1 | hazard_rs2);
        iss        = issue_valid & ~stall & issue_regwrite & (issue_rd != 5'd0);
    end

    // Next counter values with saturation at both ends; saturation flags an error.
    always_comb begin
        err_event   = 1'b0;
        cnt_next[0] = 2'd0;
        for (int r = 1; r < 32; r++) begin
            cnt_next[r] = cnt[r];
            if ((iss && (issue_rd == 5'(r))) && !(ret && (wb_rd == 5'(r)))) begin
                if (cnt[r] == 2'd3) begin
                    err_event = 1'b1;
                end else begin
                    cnt_next[r] = cnt[r] + 2'd1;
                end
            end else if (!(iss && (issue_rd == 5'(r))) && (ret && (wb_rd == 5'(r)))) begin
                if (cnt[r] == 2'd0) begin
                    err_event = 1'b1;
                end else begin
                    cnt_next[r] = cnt[r] - 2'd1;
                end
            end
        end
    end

    // Pending view: one bit per register with any write still in flight.
    always_comb begin
        pending = 32'd0;
        for (int r = 1; r < 32; r++) begin
            pending[r] = (cnt[r] != 2'd0);
        end
    end

    // State update: reset wins, flush clears counters only, stall counter saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= 2'd0;
            end
            sb_error     <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= flush ? 2'd0 : cnt_next[r];
            end
            if (err_event && !flush) begin
                sb_error <= 1'b1;
            end
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// tb/tb_register_scoreboard.sv - directed and random checks against an arithmetic scoreboard model
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_regwrite = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        wb_valid = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] pending;
    logic [15:0] stall_cycles;
    logic        sb_error;

    int errors = 0;
    int checks = 0;

    // Reference state: plain integer counts of writes in flight.
    int m_cnt [32];
    bit m_err;
    int m_sc;

    register_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .flush(flush),
        .stall(stall), .pending(pending), .stall_cycles(stall_cycles), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ret();
        return wb_valid && wb_regwrite && (wb_rd != 5'd0);
    endfunction

    function automatic bit m_hazard(input logic use_s, input logic [4:0] s);
        int c;
        c = m_cnt[s] - ((m_ret() && (wb_rd == s)) ? 1 : 0);
        return use_s && (s != 5'd0) && (c != 0);
    endfunction

    function automatic bit m_stall();
        return !flush && (m_hazard(id_use_rs1, id_rs1) || m_hazard(id_use_rs2, id_rs2));
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = '0;
        for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] > 0);
        return p;
    endfunction

    // Called at a negedge with inputs applied: check, clock once, advance model.
    task automatic tick();
        bit st;
        bit iss;
        int n;
        #1;
        st = m_stall();
        check("stall", {31'd0, stall}, {31'd0, st});
        check("pending", pending, m_pending());
        check("stall_cycles", {16'd0, stall_cycles}, m_sc);
        check("sb_error", {31'd0, sb_error}, {31'd0, m_err});
        iss = issue_valid && !st && issue_regwrite && (issue_rd != 5'd0);
        @(posedge clk);
        if (!rst) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_err = 0;
            m_sc  = 0;
        end else begin
            if (flush) begin
                foreach (m_cnt[r]) m_cnt[r] = 0;
            end else begin
                for (int r = 1; r < 32; r++) begin
                    n = m_cnt[r] + ((iss && issue_rd == r) ? 1 : 0) - ((m_ret() && wb_rd == r) ? 1 : 0);
                    if (n > 3) begin n = 3; m_err = 1; end
                    if (n < 0) begin n = 0; m_err = 1; end
                    m_cnt[r] = n;
                end
            end
            if (st && m_sc < 65535) m_sc++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 0; issue_regwrite = 0; issue_rd = 0;
        wb_valid = 0; wb_regwrite = 0; wb_rd = 0;
        flush = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        issue_valid = 1; issue_regwrite = 1; issue_rd = rd;
    endtask

    task automatic do_retire(input logic [4:0] rd);
        wb_valid = 1; wb_regwrite = 1; wb_rd = rd;
    endtask

    initial begin
        // Initial reset before the model is meaningful.
        rst = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_err = 0; m_sc = 0;

        // Reset state with a source read and no issues.
        tick();
        rst = 1;
        id_rs1 = 5; id_use_rs1 = 1;
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_pending", pending, 32'd0);
        check("reset_sc", {16'd0, stall_cycles}, 32'd0);
        tick();

        // Producer rd=5 in EX/MEM; consumer stalls two cycles then uses forwarding.
        idle(); do_issue(5);
        tick();
        idle(); id_rs1 = 5; id_use_rs1 = 1;
        #1 check("raw_stall_c1", {31'd0, stall}, 32'd1);
        tick();
        #1 check("raw_stall_c2", {31'd0, stall}, 32'd1);
        tick();
        do_retire(5);
        #1 check("raw_fwd_c3", {31'd0, stall}, 32'd0);
        check("raw_pend_c3", {31'd0, pending[5]}, 32'd1);
        tick();
        idle();
        check("raw_pend_c4", {31'd0, pending[5]}, 32'd0);
        check("raw_sc", {16'd0, stall_cycles}, 32'd2);
        tick();

        // Overflow: fourth issue to x7 saturates and sets the sticky error.
        for (int i = 0; i < 4; i++) begin idle(); do_issue(7); tick(); end
        idle();
        check("ovf_err", {31'd0, sb_error}, 32'd1);
        check("ovf_pend7", {31'd0, pending[7]}, 32'd1);
        for (int i = 0; i < 3; i++) begin idle(); do_retire(7); tick(); end
        idle();
        check("ovf_drain", {31'd0, pending[7]}, 32'd0);
        check("ovf_sticky", {31'd0, sb_error}, 32'd1);

        // Same-cycle issue and retire of x9 leaves one write outstanding.
        rst = 0; tick(); rst = 1;
        idle(); do_issue(9); tick();
        idle(); do_issue(9); do_retire(9); tick();
        idle(); id_rs2 = 9; id_use_rs2 = 1;
        #1 check("same_stall", {31'd0, stall}, 32'd1);
        check("same_pend9", {31'd0, pending[9]}, 32'd1);
        check("same_noerr", {31'd0, sb_error}, 32'd0);
        tick();
        idle(); do_retire(9); tick();

        // Flush with two x3 writes in flight.
        idle(); do_issue(3); tick();
        idle(); do_issue(3); tick();
        idle(); id_rs1 = 3; id_use_rs1 = 1; flush = 1;
        #1 check("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 0;
        #1 check("flush_pend", pending, 32'd0);
        check("flush_unstall", {31'd0, stall}, 32'd0);
        check("flush_err", {31'd0, sb_error}, 32'd0);
        tick();

        // x0 is never tracked; issues during a stall are dropped.
        idle(); do_issue(0); id_rs1 = 0; id_use_rs1 = 1; tick();
        idle(); id_rs1 = 0; id_use_rs1 = 1;
        #1 check("x0_stall", {31'd0, stall}, 32'd0);
        check("x0_pend", pending, 32'd0);
        tick();
        idle(); do_issue(4); tick();
        idle(); id_rs1 = 4; id_use_rs1 = 1; do_issue(6); tick();
        idle();
        check("drop_pend6", {31'd0, pending[6]}, 32'd0);
        do_retire(4); tick();
        idle(); tick();

        // Random traffic over a small register window to exercise hazards.
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 99) != 0);
            flush          = ($urandom_range(0, 29) == 0);
            id_rs1         = 5'($urandom_range(0, 7));
            id_rs2         = 5'($urandom_range(0, 7));
            id_use_rs1     = 1'($urandom);
            id_use_rs2     = 1'($urandom);
            issue_valid    = 1'($urandom);
            issue_regwrite = ($urandom_range(0, 3) != 0);
            issue_rd       = 5'($urandom_range(0, 7));
            wb_valid       = 1'($urandom);
            wb_regwrite    = ($urandom_range(0, 3) != 0);
            wb_rd          = 5'($urandom_range(0, 7));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Tracks which architectural registers have a write in flight between issue (ID→EX) and write-back, and raises a stall for any decode-stage instruction whose source registers cannot yet be supplied by the register file or by the MEM/WB forwarding path. It sits beside the ID stage and complements the single-source MEM/WB forwarding unit. The forwarding unit resolves consumers once a producer reaches write-back; this block interlocks consumers while the producer is still in EX or MEM.

## Interface
- No parameters: 32 registers, 2-bit in-flight counters, 16-bit stall counter.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  source is actually read
- issue_valid  in  1  ID instruction advances to EX this cycle
- issue_regwrite  in  1  issuing instruction writes a register
- issue_rd  in  5  destination of issuing instruction
- wb_valid  in  1  instruction retires from WB this cycle
- wb_regwrite  in  1  retiring instruction writes a register
- wb_rd  in  5  destination of retiring instruction
- flush  in  1  kill all in-flight instructions (branch/jump redirect)
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- pending  out  32  bit r = counter r nonzero; bit 0 always 0
- stall_cycles  out  16  saturating count of cycles with stall=1
- sb_error  out  1  sticky: counter overflow or underflow occurred

## Operation
- State: cnt[r], 2 bits, for r=1..31. cnt[0] is constant 0.
- Effective issue: iss = issue_valid & ~stall & issue_regwrite & (issue_rd≠0).
- Effective retire: ret = wb_valid & wb_regwrite & (wb_rd≠0).
- Counter update per register r each edge:
  - iss to r only: cnt+1.
  - ret from r only: cnt−1.
  - both, or neither: unchanged.
- Overflow: iss to r with cnt[r]=3 → cnt stays 3, sb_error←1.
- Underflow: ret from r with cnt[r]=0 → cnt stays 0, sb_error←1.
- Flush: all cnt←0 at the edge, overriding same-cycle iss and ret. No error is raised for the ignored ret. stall_cycles and sb_error are unaffected.
- Hazard on source s (rs1 or rs2): id_use_s & (s≠0) & (cnt[s] − (ret & wb_rd==s)) ≠ 0. A producer retiring this cycle is covered by MEM/WB forwarding and does not stall.
- stall = hazard_rs1 | hazard_rs2 | (0 while flush=1).
- issue_valid while stall=1 is ignored for counting.
- stall_cycles increments on each edge with stall=1, saturates at 0xFFFF.

## Timing
- stall and pending are combinational from current counters and current wb_* inputs. No register is in the stall path except cnt.
- Counter changes are visible on pending one cycle after the iss or ret edge.
- Minimum issue-to-unstall latency for a dependent instruction equals producer EX→WB depth. The last stall cycle is the one before the producer's WB cycle.
- Reset (rst=0 at edge) has priority over everything else:
  - all cnt←0, sb_error←0, stall_cycles←0.
  - Consequently stall=0 and pending=0.
  - Reset mid-operation discards all in-flight state.
- sb_error clears only on reset.

## Test plan
- Reset, then id_rs1=5, id_use_rs1=1 with no issues → stall=0, pending=0, stall_cycles=0.
- Issue rd=5 (cycle 0); ID reads rs1=5 from cycle 1 → stall=1 in cycles 1–2. In cycle 3, wb_rd=5 retires → stall=0; pending[5]=0 in cycle 4; stall_cycles=2.
- Issue rd=7 three times, then a fourth issue with stall=0 → cnt[7]=3, sb_error=1, pending[7]=1. Three retires of rd=7 → pending[7]=0.
- Same-cycle issue rd=9 and retire rd=9 with cnt[9]=1 → cnt[9] stays 1. ID reading rs2=9 stalls.
- Two writes to x3 in flight; assert flush → next cycle pending=0, stall=0, sb_error unchanged.
- rd=0 issues and x0 reads → pending[0]=0, never stall. issue_valid with stall=1 → no counter change.
